dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  - Shares the single DataMemory port between the core load/store path (req 0) and an external loader/debug master (req 1).
//  - Sits between the core datapath / loader and DataMemory.
//  - Grants are same-cycle, so the single-cycle core loses no time when uncontended.
//  - A core that is denied the port receives a stall.
//  - Round-robin fairness, burst locking with a max burst length.
// PARAMETERS
//  - AW         64  address width
//  - DW         64  data width
//  - MAX_BURST  8   max consecutive locked grants to one owner while the other is requesting (>=1)
// PORTS
//  - CLK          in   1   clock; all state updates on posedge
//  - reset        in   1   asynchronous, active-high reset
//  - c_req        in   1   core requests port this cycle
//  - c_wr         in   1   core access is a write (else read)
//  - c_lock       in   1   core wants to keep port next cycle
//  - c_addr       in   AW  core address
//  - c_wdata      in   DW  core write data
//  - c_gnt        out  1   core owns port this cycle
//  - c_stall      out  1   c_req & ~c_gnt
//  - l_req        in   1   loader request (same semantics as core)
//  - l_wr         in   1   loader write
//  - l_lock       in   1   loader lock
//  - l_addr       in   AW  loader address
//  - l_wdata      in   DW  loader write data
//  - l_gnt        out  1   loader owns port this cycle
//  - rdata        out  DW  mem_rdata passthrough, valid in the grant cycle
//  - mem_addr     out  AW  to DataMemory.Address
//  - mem_wdata    out  DW  to DataMemory.WriteData
//  - mem_read     out  1   to DataMemory.MemoryRead
//  - mem_write    out  1   to DataMemory.MemoryWrite
//  - mem_rdata    in   DW  from DataMemory.ReadData
// BEHAVIOUR
//  - State: owner FSM {IDLE, CORE, LDR}; rr_ptr (0 = core preferred); burst_cnt [$clog2(MAX_BURST+1)-1:0].
//  - Reset (async):
//    - owner = IDLE, rr_ptr = 0, burst_cnt = 0.
//    - Combinational outputs then give c_gnt = c_req, l_gnt = 0 when l_req = 0.
//  - Grant (combinational, 0 latency):
//    - CORE/LDR with the owner's req high and burst_cnt < MAX_BURST: grant the owner, regardless of the other req.
//    - CORE/LDR with the owner's req low, or with the other req high and burst_cnt == MAX_BURST: arbitrate as IDLE.
//    - IDLE: a single requester wins; if both request, rr_ptr picks the winner.
//    - Exactly one grant at most; no req -> no grant.
//  - Mem mux:
//    - Granted side drives mem_addr and mem_wdata.
//    - mem_read = gnt & ~wr; mem_write = gnt & wr.
//    - No grant: mem_addr = 0, mem_wdata = 0, mem_read = 0, mem_write = 0.
//  - Writes commit on the DataMemory clock edge of the grant cycle.
//  - Next state (posedge):
//    - Winner W with W's lock = 1: owner <= W; burst_cnt <= (owner == W) ? burst_cnt + 1 : 1.
//    - Otherwise: owner <= IDLE, burst_cnt <= 0.
//    - Whenever a grant is issued: rr_ptr <= ~winner, so the loser is preferred next.
//    - The burst counter saturates at MAX_BURST.
//    - A forced release (cap reached while the other side waits) hands over that same cycle.
//    - The capped owner is not regranted until the other side has had at least one grant.
//  - Boundaries:
//    - Lock asserted with req low is ignored.
//    - When the other side is idle, a lock may run past MAX_BURST; burst_cnt holds at MAX_BURST.
//    - Reset mid-burst drops ownership immediately.
// CONFIGURATION
//  - Macro DMEM_ARB_STATS_EN.
//  - When defined, adds outputs:
//    - c_wait_cnt [31:0]: cycles with c_stall = 1.
//    - l_gnt_cnt [31:0]: loader grant count.
//    - Both are wrapping counters, cleared by reset.
//  - When undefined, these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package dmem_arb_pkg holds:
//    - owner_t enum {OWN_IDLE = 2'd0, OWN_CORE = 2'd1, OWN_LDR = 2'd2};
//    - localparams REQ_CORE = 0, REQ_LDR = 1.
//  - One sub-module, dmem_arb_pick: the pure combinational 2-way round-robin pick.
//    - Inputs: req[1:0], rr_ptr, force_mask[1:0].
//    - Outputs: gnt[1:0], winner.
//  - FSM, counters and mux remain in the top.
// TESTING
//  - Reset, then c_req = 1 read addr 0x10 -> c_gnt = 1, mem_read = 1, mem_addr = 0x10, c_stall = 0.
//  - Both req in the same cycle after reset -> core wins (rr_ptr = 0).
//    - Next cycle, both still requesting -> loader wins; thereafter alternate.
//  - Loader lock held with c_req = 1 throughout, MAX_BURST = 8 -> loader granted 8 cycles.
//    - Then core granted 1 cycle; c_stall = 1 for exactly those 8 cycles.
//  - Loader lock with c_req = 0 for 20 cycles -> 20 consecutive loader grants; burst_cnt holds at 8.
//  - Loader write 0xDEAD to 0x40, then core read 0x40 -> rdata = 0xDEAD; mem_write pulses 1 cycle.
//  - reset asserted mid-burst (async, between edges) -> grants drop that instant, owner = IDLE.
//    - After release, tied requests go to the core.
//    - With DMEM_ARB_STATS_EN, counters = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DataMemory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_LDR  = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the DataMemory arbiter: core and loader request ports,
// grant/stall returns and the shared DataMemory port.
// Optional statistics outputs are present when DMEM_ARB_STATS_EN is defined.
interface dmem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          c_req;
  logic          c_wr;
  logic          c_lock;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_stall;

  logic          l_req;
  logic          l_wr;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;

  logic [DW-1:0] rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   c_wait_cnt;
  logic [31:0]   l_gnt_cnt;
`endif

  // Arbiter side
  modport slave (
    input  c_req, c_wr, c_lock, c_addr, c_wdata,
    input  l_req, l_wr, l_lock, l_addr, l_wdata,
    input  mem_rdata,
    output c_gnt, c_stall, l_gnt, rdata,
    output mem_addr, mem_wdata, mem_read, mem_write
`ifdef DMEM_ARB_STATS_EN
    , output c_wait_cnt, l_gnt_cnt
`endif
  );

  // Requester / memory side
  modport master (
    output c_req, c_wr, c_lock, c_addr, c_wdata,
    output l_req, l_wr, l_lock, l_addr, l_wdata,
    output mem_rdata,
    input  c_gnt, c_stall, l_gnt, rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write
`ifdef DMEM_ARB_STATS_EN
    , input c_wait_cnt, l_gnt_cnt
`endif
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Pure combinational 2-way round-robin pick. force_mask removes a requester
// from consideration (used for burst holding and forced release).
module dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic [1:0] force_mask,
  output logic [1:0] gnt,
  output logic       winner
);

  logic [1:0] eff;

  // Single eligible requester wins; a tie is broken by rr_ptr.
  always_comb begin
    eff    = req & ~force_mask;
    gnt    = 2'b00;
    winner = 1'b0;
    case (eff)
      2'b01: begin
        gnt    = 2'b01;
        winner = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = 1'b1;
      end
      2'b11: begin
        winner = rr_ptr;
        gnt    = rr_ptr ? 2'b10 : 2'b01;
      end
      default: begin
        gnt    = 2'b00;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the core (req 0) and the
// loader/debug master (req 1). Same-cycle grants, round-robin on ties,
// lockable bursts capped at MAX_BURST while the other side is waiting.
// Optional macro DMEM_ARB_STATS_EN adds c_wait_cnt / l_gnt_cnt counters.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   OWN_IDLE | nobody holds the port; plain round-robin arbitration
//   OWN_CORE | core locked the port last cycle; kept while it requests
//   OWN_LDR  | loader locked the port last cycle; kept while it requests
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 64,
  parameter int DW        = 64,
  parameter int MAX_BURST = 8
) (
  input  logic           CLK,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int            CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  owner_t        owner, owner_nxt;
  logic          rr_ptr, rr_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;

  logic [1:0]    req;
  logic [1:0]    lock;
  logic [1:0]    force_mask;
  logic [1:0]    gnt;
  logic          winner;
  logic          capped;
  logic          win_lock;
  owner_t        win_own;

  assign req  = {bus.l_req,  bus.c_req};
  assign lock = {bus.l_lock, bus.c_lock};

  // Holding owner masks the other side; a capped owner with a waiting
  // competitor is masked itself so the port is handed over this cycle.
  always_comb begin
    capped     = (burst_cnt == CAP);
    force_mask = 2'b00;
    case (owner)
      OWN_CORE: begin
        if (req[REQ_CORE]) begin
          if (!capped || !req[REQ_LDR]) force_mask[REQ_LDR]  = 1'b1;
          else                          force_mask[REQ_CORE] = 1'b1;
        end
      end
      OWN_LDR: begin
        if (req[REQ_LDR]) begin
          if (!capped || !req[REQ_CORE]) force_mask[REQ_CORE] = 1'b1;
          else                           force_mask[REQ_LDR]  = 1'b1;
        end
      end
      default: force_mask = 2'b00;
    endcase
  end

  dmem_arb_pick u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .force_mask (force_mask),
    .gnt        (gnt),
    .winner     (winner)
  );

  // Next owner, burst counter and round-robin pointer.
  always_comb begin
    owner_nxt = OWN_IDLE;
    cnt_nxt   = '0;
    rr_nxt    = rr_ptr;
    win_lock  = winner ? lock[REQ_LDR] : lock[REQ_CORE];
    win_own   = winner ? OWN_LDR : OWN_CORE;
    if (|gnt) begin
      rr_nxt = ~winner;
      if (win_lock) begin
        owner_nxt = win_own;
        if (owner == win_own) cnt_nxt = capped ? CAP : burst_cnt + CW'(1);
        else                  cnt_nxt = CW'(1);
      end
    end
  end

  // State register; reset drops ownership immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      owner     <= OWN_IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Grant outputs and DataMemory port mux.
  always_comb begin
    bus.c_gnt     = gnt[REQ_CORE];
    bus.l_gnt     = gnt[REQ_LDR];
    bus.c_stall   = bus.c_req & ~gnt[REQ_CORE];
    bus.rdata     = bus.mem_rdata;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (gnt[REQ_CORE]) begin
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
      bus.mem_read  = ~bus.c_wr;
      bus.mem_write = bus.c_wr;
    end else if (gnt[REQ_LDR]) begin
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
      bus.mem_read  = ~bus.l_wr;
      bus.mem_write = bus.l_wr;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] c_wait_q;
  logic [31:0] l_gnt_q;

  // Wrapping statistics: core stall cycles and loader grants.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      c_wait_q <= '0;
      l_gnt_q  <= '0;
    end else begin
      if (bus.c_req && !gnt[REQ_CORE]) c_wait_q <= c_wait_q + 32'd1;
      if (gnt[REQ_LDR])                l_gnt_q  <= l_gnt_q + 32'd1;
    end
  end

  assign bus.c_wait_cnt = c_wait_q;
  assign bus.l_gnt_cnt  = l_gnt_q;
`endif

endmodule
